// File: rtl/uart_tx_buffered.sv
// rtl/uart_tx_buffered.sv - buffered 8N1 UART transmitter with TX FIFO and status word
//
// Ports:
//   clk          system clock
//   reset        synchronous active-high reset
//   write_tx     push write_data into the TX FIFO this cycle
//   write_data   byte to transmit
//   clear_ovf    clear the sticky overflow flag
//   clk_per_bit  clock cycles per serial bit (0 is treated as 1)
//   tx           registered serial output, idle high
//   tx_busy      FIFO non-empty or a frame in progress
//   status_data  {20'b0, ovf, busy, full, empty, 3'b0, count[4:0]}
module uart_tx_buffered #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        write_tx,
  input  logic [7:0]  write_data,
  input  logic        clear_ovf,
  input  logic [15:0] clk_per_bit,
  output logic        tx,
  output logic        tx_busy,
  output logic [31:0] status_data
);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          ovf;
  logic [7:0]    shreg;
  logic [15:0]   period;
  logic [15:0]   bit_cnt;
  logic [2:0]    bit_idx;

  logic          empty;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic          bit_done;
  logic [4:0]    count_field;

  assign empty = (count == '0);
  assign full  = (count == FULL_COUNT);

  // The serializer only takes a byte while idle, and only one that was already
  // in the FIFO at the start of the cycle, so a byte written into an empty FIFO
  // is never popped on the same edge.
  assign pop  = (state == IDLE) && !empty;

  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign push = write_tx && (!full || pop);
  assign drop = write_tx && full && !pop;

  // The bit period is latched at frame start, so clk_per_bit may change freely
  // mid-frame without disturbing the frame on the line.
  assign bit_done = (bit_cnt == (period - 16'd1));

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= write_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      // A dropping write beats a simultaneous clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clear_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  // tx is assigned together with the state transition so the line changes on
  // the same edge the FSM enters the new bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      tx      <= 1'b1;
      shreg   <= '0;
      period  <= 16'd1;
      bit_cnt <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (!empty) begin
            shreg   <= mem[rd_ptr];
            period  <= (clk_per_bit == 16'd0) ? 16'd1 : clk_per_bit;
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= 1'b0;
            state   <= START;
          end
        end
        START: begin
          if (bit_done) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            tx      <= shreg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        DATA: begin
          if (bit_done) begin
            bit_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        STOP: begin
          if (bit_done) begin
            bit_cnt <= '0;
            tx      <= 1'b1;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 16'd1;
          end
        end
        default: begin
          tx    <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

  assign tx_busy     = (state != IDLE) || !empty;
  assign count_field = 5'(count);
  assign status_data = {20'b0, ovf, tx_busy, full, empty, 3'b0, count_field};

endmodule
